router_sync: RTL and testbench
==============================

# router_sync

Input-side port controller for the 1x3 router. It sits between the router FSM and the three output FIFOs. It latches the destination address at header time, steers the FSM's write strobe and the full flags to and from the addressed FIFO, and drives per-port valid flags. A per-port stall watchdog issues a one-cycle soft reset when a destination leaves a valid packet unread for too long.

## Interface
Parameters:
- TIMEOUT, default 30: consecutive stalled cycles before a port's soft reset fires; legal range 2 to 2^CNT_W.
- CNT_W, default 5: width of each watchdog counter.

Ports:
- clock, input, 1: sole clock; all state changes on the rising edge.
- resetn, input, 1: asynchronous, active-low reset.
- detect_add, input, 1: FSM is in address-decode; load address.
- write_enb_reg, input, 1: FSM requests a FIFO write this cycle.
- data_in, input, 2: header address field (00/01/10 valid, 11 = no port).
- read_enb_0/1/2, input, 1 each: destination read strobe per port.
- empty_0/1/2, input, 1 each: FIFO empty flags.
- full_0/1/2, input, 1 each: FIFO full flags.
- write_enb, output, 3: one-hot FIFO write enables; bit n drives FIFO n.
- fifo_full, output, 1: full flag of the addressed FIFO, returned to the FSM.
- vld_out_0/1/2, output, 1 each: port n holds data (!empty_n).
- soft_reset_0/1/2, output, 1 each: registered one-cycle FIFO flush and FSM abort pulse.

## Operation
- Address register addr[1:0]:
  - loads data_in on any edge where detect_add=1, otherwise holds;
  - reset value 2'b11 (no port).
- write_enb:
  - combinational; the bit selected by addr equals write_enb_reg;
  - addr=11 gives 3'b000 regardless of write_enb_reg.
- fifo_full:
  - combinational mux of full_n selected by addr;
  - addr=11 gives 0.
- vld_out_n: combinational, !empty_n.
- Watchdog, one per port, independent. Counter cnt_n is CNT_W bits wide; stall_n = vld_out_n & !read_enb_n.
  - stall_n=0 at an edge: cnt_n←0, soft_reset_n←0.
  - stall_n=1 and cnt_n<TIMEOUT-1: cnt_n←cnt_n+1, soft_reset_n←0.
  - stall_n=1 and cnt_n==TIMEOUT-1: cnt_n←0, soft_reset_n←1.
- Result: soft_reset_n goes high for exactly one cycle after the TIMEOUT-th consecutive stalled edge. A continued stall re-fires every TIMEOUT edges.
- Ports never interact: two or three soft resets may assert in the same cycle.
- The watchdog runs regardless of addr; a soft reset does not alter addr.

## Timing
- Reset (async assert, sync release): addr=11, all cnt_n=0, soft_reset_n=0, write_enb=000, fifo_full=0. vld_out_n follows empty_n even during reset.
- Address latency: data_in sampled with detect_add=1 steers write_enb and fifo_full from the next cycle onward.
- detect_add and write_enb_reg high in the same cycle: the write goes to the old addr, and the new addr takes effect next cycle.
- write_enb and fifo_full have zero latency from write_enb_reg, full_n and addr.
- Watchdog edge cases:
  - a read_enb_n pulse on any stalled cycle restarts the count from 0;
  - vld_out_n dropping, for example after the FIFO flushes, also restarts the count;
  - stall_n high on the firing edge still clears cnt_n and pulses soft_reset_n.
- Reset asserted mid-count: counters and pulses clear immediately (asynchronously).

## Structure
- Shared package router_pkg holds:
  - ADDR_P0=2'b00, ADDR_P1=2'b01, ADDR_P2=2'b10, ADDR_NONE=2'b11;
  - default TIMEOUT=30 and CNT_W=5 constants.
- One sub-module, router_stall_timer:
  - parameters TIMEOUT and CNT_W;
  - ports clock, resetn, vld, rd, soft_reset;
  - instantiated three times.
- Address latch, write decode and full mux live in the top level.

## Test plan
- Reset: hold resetn=0 with empty_0=0 → write_enb=000, fifo_full=0, soft_reset_*=0, vld_out_0=1.
- Address steering: detect_add=1, data_in=01; next cycle write_enb_reg=1, full_1=1 → write_enb=010, fifo_full=1. Repeat with data_in=11 → write_enb=000, fifo_full=0.
- Timeout: empty_2=0 and read_enb_2=0 for 30 edges → soft_reset_2 high for exactly the 31st cycle only; still stalled → next pulse 30 cycles later.
- Read rescue: stall port 0 for 29 edges, pulse read_enb_0 once, stall 29 more → no soft_reset_0.
- Simultaneous events: stall all three ports from the same edge → all soft_reset_n pulse in the same cycle. Separately, detect_add and write_enb_reg together with the addr change 00→10 → write lands on bit 0.
- Reset mid-count: stall port 1 for 20 edges, assert resetn=0 asynchronously, then release → cnt_1 restarts; soft_reset_1 fires 30 stalled edges after release.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: port address codes and watchdog defaults.
package router_pkg;

  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_P0   = 2'b00;
  localparam logic [ADDR_W-1:0] ADDR_P1   = 2'b01;
  localparam logic [ADDR_W-1:0] ADDR_P2   = 2'b10;
  localparam logic [ADDR_W-1:0] ADDR_NONE = 2'b11;

  localparam int unsigned DEF_TIMEOUT = 30;
  localparam int unsigned DEF_CNT_W   = 5;

endpackage

// File: rtl/router_stall_timer.sv
// Per-port stall watchdog: pulses soft_reset for one cycle after TIMEOUT
// consecutive edges where the port holds data that nobody reads.
module router_stall_timer
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             stall;

  assign stall = vld & ~rd;

  // Count consecutive stalled edges; wrap to zero on the firing edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!stall) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt >= LAST) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync.sv
// Router input-side port controller: latches the header address, steers write
// strobes and full flags to the addressed FIFO, and runs per-port watchdogs.
module router_sync
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic              write_enb_reg,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              read_enb_0,
  input  logic              read_enb_1,
  input  logic              read_enb_2,
  input  logic              empty_0,
  input  logic              empty_1,
  input  logic              empty_2,
  input  logic              full_0,
  input  logic              full_1,
  input  logic              full_2,
  output logic [2:0]        write_enb,
  output logic              fifo_full,
  output logic              vld_out_0,
  output logic              vld_out_1,
  output logic              vld_out_2,
  output logic              soft_reset_0,
  output logic              soft_reset_1,
  output logic              soft_reset_2
);

  logic [ADDR_W-1:0] addr;

  // Destination address, captured while the FSM decodes the header.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr <= ADDR_NONE;
    end else if (detect_add) begin
      addr <= data_in;
    end
  end

  // Zero-latency steering; the "no port" code gates everything off.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr)
      ADDR_P0: begin
        write_enb[0] = write_enb_reg;
        fifo_full    = full_0;
      end
      ADDR_P1: begin
        write_enb[1] = write_enb_reg;
        fifo_full    = full_1;
      end
      ADDR_P2: begin
        write_enb[2] = write_enb_reg;
        fifo_full    = full_2;
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

  router_stall_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_0 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_0),
    .rd         (read_enb_0),
    .soft_reset (soft_reset_0)
  );

  router_stall_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_1 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_1),
    .rd         (read_enb_1),
    .soft_reset (soft_reset_1)
  );

  router_stall_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_2 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_2),
    .rd         (read_enb_2),
    .soft_reset (soft_reset_2)
  );

endmodule

// File: tb/tb_router_sync.sv
// Scoreboard bench for router_sync: directed scenarios then random traffic,
// compared against a run-length model of address steering and stall watchdogs.
module tb_router_sync;

  localparam int TO = 30;

  logic       clock = 1'b0;
  logic       resetn;
  logic       detect_add, write_enb_reg;
  logic [1:0] data_in;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  router_sync #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clock(clock), .resetn(resetn), .detect_add(detect_add),
    .write_enb_reg(write_enb_reg), .data_in(data_in),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .full_0(full_0), .full_1(full_1), .full_2(full_2),
    .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] we;
    logic       ff;
    logic [2:0] vld;
    logic [2:0] sr;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   sr_seen  = 0;

  // Reference model: address as an integer (3 = none), stall run lengths.
  int         m_addr = 3;
  int         run[3];
  logic [2:0] m_sr = 3'b000;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
  endtask

  // Drive one cycle of inputs at the falling edge, queue expectations, then
  // advance the model across the following rising edge.
  task automatic step(input logic rst, input logic da, input logic [1:0] din,
                      input logic wer, input logic [2:0] rd,
                      input logic [2:0] emp, input logic [2:0] full,
                      input string tag);
    exp_t e;
    @(negedge clock);
    resetn = rst; detect_add = da; data_in = din; write_enb_reg = wer;
    {read_enb_2, read_enb_1, read_enb_0} = rd;
    {empty_2, empty_1, empty_0} = emp;
    {full_2, full_1, full_0} = full;
    if (!rst) begin
      m_addr = 3;
      m_sr   = 3'b000;
      for (int p = 0; p < 3; p++) run[p] = 0;
    end
    e.we  = (m_addr != 3 && wer) ? 3'(1 << m_addr) : 3'b000;
    e.ff  = (m_addr != 3) ? full[m_addr] : 1'b0;
    e.vld = ~emp;
    e.sr  = m_sr;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clock);
    if (rst) begin
      if (da) m_addr = int'(din);
      for (int p = 0; p < 3; p++) begin
        if (!emp[p] && !rd[p]) begin
          run[p]++;
          m_sr[p] = (run[p] % TO == 0);
        end else begin
          run[p]  = 0;
          m_sr[p] = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic [2:0] rd, input logic [2:0] emp, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00, 1'b0, rd, emp, 3'b000, tag);
  endtask

  // Monitor: outputs are sampled mid-low-phase, after the stimulus settles.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".write_enb"}, write_enb, e.we);
        check({e.tag, ".fifo_full"}, {2'b00, fifo_full}, {2'b00, e.ff});
        check({e.tag, ".vld_out"}, {vld_out_2, vld_out_1, vld_out_0}, e.vld);
        check({e.tag, ".soft_reset"}, {soft_reset_2, soft_reset_1, soft_reset_0}, e.sr);
        if (e.sr != 3'b000) sr_seen++;
      end
    end
  end

  initial begin
    logic [2:0] rd, emp, full;
    for (int p = 0; p < 3; p++) run[p] = 0;
    resetn = 1'b0; detect_add = 1'b0; write_enb_reg = 1'b0; data_in = 2'b00;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    {empty_2, empty_1, empty_0} = 3'b111;
    {full_2, full_1, full_0} = 3'b000;

    // Reset with port 0 holding data.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 1'b1, 3'b000, 3'b110, 3'b111, "reset");

    // Address steering to port 1, then to "no port".
    step(1'b1, 1'b1, 2'b01, 1'b0, 3'b000, 3'b111, 3'b000, "steer_load1");
    step(1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 3'b111, 3'b010, "steer_p1");
    step(1'b1, 1'b1, 2'b11, 1'b0, 3'b000, 3'b111, 3'b010, "steer_load3");
    step(1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 3'b111, 3'b111, "steer_none");

    // Port 2 timeout and re-fire.
    idle(2 * TO + 5, 3'b000, 3'b011, "timeout_p2");
    idle(2, 3'b000, 3'b111, "clear");

    // Read rescue on port 0.
    idle(TO - 1, 3'b000, 3'b110, "rescue_a");
    idle(1, 3'b001, 3'b110, "rescue_rd");
    idle(TO - 1, 3'b000, 3'b110, "rescue_b");
    idle(2, 3'b000, 3'b111, "clear");

    // All three ports stall from the same edge.
    idle(TO + 3, 3'b000, 3'b000, "all_stall");
    idle(2, 3'b000, 3'b111, "clear");

    // Address change 00 -> 10 with a write in the same cycle.
    step(1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 3'b111, 3'b000, "same_load0");
    step(1'b1, 1'b1, 2'b10, 1'b1, 3'b000, 3'b111, 3'b000, "same_old");
    step(1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 3'b111, 3'b100, "same_new");

    // Reset in the middle of a port 1 count, then a full fresh timeout.
    idle(20, 3'b000, 3'b101, "mid_a");
    step(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b101, 3'b000, "mid_rst");
    idle(TO + 3, 3'b000, 3'b101, "mid_b");

    // Random traffic; reads and drains are rare so timeouts do occur.
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 3; p++) begin
        rd[p]   = ($urandom_range(0, 39) == 0);
        emp[p]  = ($urandom_range(0, 59) == 0);
        full[p] = 1'($urandom_range(0, 1));
      end
      step(($urandom_range(0, 799) != 0), ($urandom_range(0, 7) == 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd, emp, full, "random");
    end

    repeat (3) @(negedge clock);
    #5;
    check("queue_drained", 3'(exp_q.size()), 3'b000);
    check("pulses_observed", {2'b00, sr_seen > 5}, 3'b001);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
